egress_queue_ctrl: RTL and testbench
====================================

// Module: egress_queue_ctrl
// PURPOSE
//  Sequencer for one egress port's metadata queue, a simple dual-port RAM with registered read.
//  Owns the write/read pointers and the occupancy count, and accepts crossbar writes.
//  Drains entries to the interface over a valid/ack handshake.
//  Drives almost_full backpressure to the crossbar scheduler and counts dropped writes.
// PARAMETERS
//  PACKET_CNT      1024  queue depth in entries; need not be a power of two
//  META_WIDTH      32    metadata word width
//  AFULL_MARGIN    4     almost_full asserts when count >= PACKET_CNT-AFULL_MARGIN
//  DROP_CNT_WIDTH  16    width of the saturating drop counter
// PORTS
//  clk        in   1                    clock; the only clock
//  reset      in   1                    synchronous, active-high
//  in_data    in   META_WIDTH           metadata word from crossbar
//  in_en      in   1                    crossbar write strobe
//  almost_full out 1                    backpressure to scheduler
//  full       out  1                    count == PACKET_CNT
//  empty      out  1                    count == 0
//  drop_cnt   out  DROP_CNT_WIDTH       writes lost while full; saturating
//  mem_wa     out  $clog2(PACKET_CNT)   RAM write address (= wr_ptr)
//  mem_d      out  META_WIDTH           RAM write data (= in_data)
//  mem_write  out  1                    RAM write enable
//  mem_ra     out  $clog2(PACKET_CNT)   RAM read address (= rd_ptr, combinational)
//  mem_q      in   META_WIDTH           RAM read data; ra sampled at an edge, valid in the next cycle
//  out_data   out  META_WIDTH           registered word to interface
//  out_valid  out  1                    out_data holds an unacknowledged entry
//  out_ack    in   1                    interface consumed out_data
// BEHAVIOUR
//  Reset:
//   - wr_ptr, rd_ptr, count, drop_cnt, out_data and out_valid are 0; FSM is IDLE.
//   - full=0, empty=1, almost_full=0, mem_write=0.
//   - Reset mid-operation discards queue and output contents. RAM is not cleared.
//  Pointers and count:
//   - Pointers wrap at PACKET_CNT-1 -> 0.
//   - count is $clog2(PACKET_CNT)+1 bits wide, range 0..PACKET_CNT.
//  Write:
//   - in_en && !full -> mem_write=1 that cycle; wr_ptr++ and count++ at the edge.
//   - in_en && full -> no RAM write; drop_cnt++ (holds at all-ones).
//   - full is evaluated on count before update. A pop in the same cycle does not make room.
//  Pop:
//   - The FETCH->PRESENT transition captures mem_q into out_data, then rd_ptr++ and count--.
//   - Write accepted and pop in the same cycle -> count unchanged.
//  FSM:
//   - IDLE:    count!=0 -> FETCH, else stay. rd_ptr is presented to the RAM this cycle.
//   - FETCH:   mem_q valid; -> PRESENT with pop, out_valid<=1.
//   - PRESENT: out_data/out_valid held stable until out_ack.
//              out_ack && count!=0 -> FETCH; out_ack && count==0 -> IDLE; out_valid<=0 on ack.
//  Handshake:
//   - out_ack while !out_valid is ignored.
//   - Sustained throughput is 1 entry per 2 cycles under continuous ack.
//  Latency:
//   - in_en in cycle 0 into an empty queue -> out_valid=1 in cycle 3.
//  Read-during-write:
//   - Never needed. An entry is only read from the cycle after its write edge.
//  Flags:
//   - full, empty and almost_full are combinational from registered count.
// TESTING
//  - Reset, then write 0xA5 at cycle 0 -> out_valid=1, out_data=0xA5 at cycle 3;
//    ack -> out_valid=0, empty=1.
//  - Write 5 words, hold out_ack=0 -> out_data stays the first word, count=4;
//    ack each -> words emerge in order, 2 cycles apart.
//  - Fill 1024 with no ack -> full=1; 3 more writes -> drop_cnt=3, no RAM write;
//    almost_full=1 from count=1020.
//  - Write 1030 entries while draining continuously -> pointers wrap past 1023->0;
//    output sequence matches input with no loss.
//  - Write while full with out_ack in the same cycle -> write dropped, count=1023 afterwards.
//  - Assert reset while out_valid=1 and count=7 -> next cycle out_valid=0, empty=1,
//    drop_cnt=0, FSM IDLE.

Source files
------------

// File: rtl/egress_queue_ctrl_if.sv
// Signal bundle for one egress queue sequencer: crossbar write side, queue RAM
// port and the valid/ack drain toward the interface.
interface egress_queue_ctrl_if #(
    parameter int PACKET_CNT     = 1024,
    parameter int META_WIDTH     = 32,
    parameter int DROP_CNT_WIDTH = 16
);
    localparam int AW = (PACKET_CNT > 1) ? $clog2(PACKET_CNT) : 1;

    logic [META_WIDTH-1:0]     in_data;
    logic                      in_en;
    logic                      almost_full;
    logic                      full;
    logic                      empty;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt;
    logic [AW-1:0]             mem_wa;
    logic [META_WIDTH-1:0]     mem_d;
    logic                      mem_write;
    logic [AW-1:0]             mem_ra;
    logic [META_WIDTH-1:0]     mem_q;
    logic [META_WIDTH-1:0]     out_data;
    logic                      out_valid;
    logic                      out_ack;

    // The slave side is the queue controller; the master side is its environment.
    modport slave (
        input  in_data, in_en, mem_q, out_ack,
        output almost_full, full, empty, drop_cnt,
        output mem_wa, mem_d, mem_write, mem_ra, out_data, out_valid
    );

    modport master (
        output in_data, in_en, mem_q, out_ack,
        input  almost_full, full, empty, drop_cnt,
        input  mem_wa, mem_d, mem_write, mem_ra, out_data, out_valid
    );
endinterface

// File: rtl/egress_queue_ctrl.sv
// Egress metadata queue sequencer: owns the RAM pointers and occupancy, accepts
// crossbar writes, counts drops and drains entries over a valid/ack handshake.
module egress_queue_ctrl #(
    parameter int PACKET_CNT     = 1024,
    parameter int META_WIDTH     = 32,
    parameter int AFULL_MARGIN   = 4,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    egress_queue_ctrl_if.slave bus
);
    localparam int AW = (PACKET_CNT > 1) ? $clog2(PACKET_CNT) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LEVEL  = CW'(PACKET_CNT);
    localparam logic [CW-1:0] AFULL_LEVEL = CW'(PACKET_CNT - AFULL_MARGIN);
    localparam logic [AW-1:0] LAST_ADDR   = AW'(PACKET_CNT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_PRESENT
    } state_t;

    state_t                    r_state;
    state_t                    w_nextState;
    logic [AW-1:0]             r_wrPtr;
    logic [AW-1:0]             r_rdPtr;
    logic [CW-1:0]             r_count;
    logic [DROP_CNT_WIDTH-1:0] r_dropCnt;
    logic [META_WIDTH-1:0]     r_outData;
    logic                      r_outValid;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_push;
    logic                      w_drop;
    logic                      w_pop;
    logic                      w_ackTaken;

    assign w_full  = (r_count == FULL_LEVEL);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_en && !w_full && !reset;
    assign w_drop  = bus.in_en && w_full;

    // rd_ptr is on the RAM address in IDLE/PRESENT, so mem_q is ready by FETCH.
    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        w_ackTaken  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_nextState = S_FETCH;
                end
            end
            S_FETCH: begin
                w_pop       = 1'b1;
                w_nextState = S_PRESENT;
            end
            S_PRESENT: begin
                if (bus.out_ack) begin
                    w_ackTaken  = 1'b1;
                    w_nextState = w_empty ? S_IDLE : S_FETCH;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_dropCnt <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= (r_wrPtr == LAST_ADDR) ? '0 : r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= (r_rdPtr == LAST_ADDR) ? '0 : r_rdPtr + AW'(1);
            end
            // A simultaneous accepted write and pop leave the occupancy unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_dropCnt != '1)) begin
                r_dropCnt <= r_dropCnt + DROP_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_outData  <= '0;
            r_outValid <= 1'b0;
        end else if (w_pop) begin
            r_outData  <= bus.mem_q;
            r_outValid <= 1'b1;
        end else if (w_ackTaken) begin
            r_outValid <= 1'b0;
        end
    end

    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.almost_full = (r_count >= AFULL_LEVEL);
    assign bus.drop_cnt    = r_dropCnt;
    assign bus.mem_wa      = r_wrPtr;
    assign bus.mem_d       = bus.in_data;
    assign bus.mem_write   = w_push;
    assign bus.mem_ra      = r_rdPtr;
    assign bus.out_data    = r_outData;
    assign bus.out_valid   = r_outValid;
endmodule

// File: tb/tb_egress_queue_ctrl.sv
// Scoreboard bench for egress_queue_ctrl: a queue-based reference model predicts
// accepted words, drops and flags; monitors compare whenever the DUT presents output.
module tb_egress_queue_ctrl;
    localparam int DEPTH  = 1024;
    localparam int MW     = 32;
    localparam int MARGIN = 4;
    localparam int DW     = 16;
    localparam int AW     = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    egress_queue_ctrl_if #(.PACKET_CNT(DEPTH), .META_WIDTH(MW), .DROP_CNT_WIDTH(DW)) bus ();

    egress_queue_ctrl #(
        .PACKET_CNT(DEPTH),
        .META_WIDTH(MW),
        .AFULL_MARGIN(MARGIN),
        .DROP_CNT_WIDTH(DW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural queue RAM: registered read, address sampled at the edge.
    logic [MW-1:0] ram [DEPTH];
    logic [MW-1:0] ramQ = '0;
    always @(posedge clk) begin
        if (bus.mem_write) ram[bus.mem_wa] <= bus.mem_d;
        ramQ <= ram[bus.mem_ra];
    end
    assign bus.mem_q = ramQ;

    logic [MW-1:0] expQ[$];
    int            riseLog[$];
    int            accepted  = 0;
    int            popCnt    = 0;
    int            dropModel = 0;
    int            cycle     = 0;
    int            checks    = 0;
    int            errors    = 0;
    bit            inReset   = 1'b1;
    bit            expWrite  = 1'b0;
    logic [MW-1:0] expData   = '0;
    logic [AW-1:0] expWa     = '0;
    bit            prevValid = 1'b0;
    logic [MW-1:0] prevData  = '0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    function automatic int modelCount();
        return accepted - popCnt;
    endfunction

    // One cycle of stimulus; the model decides accept/drop from its own occupancy.
    task automatic applyStimulus(input bit en, input logic [MW-1:0] data, input bit ack);
        @(negedge clk);
        expWrite = 1'b0;
        if (en) begin
            if (modelCount() == DEPTH) begin
                if (dropModel < (1 << DW) - 1) dropModel++;
            end else begin
                expWrite = 1'b1;
                expData  = data;
                expWa    = AW'(accepted % DEPTH);
                expQ.push_back(data);
                accepted++;
            end
        end
        bus.in_en   = en;
        bus.in_data = data;
        bus.out_ack = ack;
    endtask

    task automatic resetTask();
        @(negedge clk);
        inReset     = 1'b1;
        reset       = 1'b1;
        bus.in_en   = 1'b0;
        bus.out_ack = 1'b0;
        expWrite    = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("rstOutValid", bus.out_valid, 0);
        checkOutput("rstOutData", bus.out_data, 0);
        checkOutput("rstEmpty", bus.empty, 1);
        checkOutput("rstFull", bus.full, 0);
        checkOutput("rstAlmostFull", bus.almost_full, 0);
        checkOutput("rstDropCnt", bus.drop_cnt, 0);
        checkOutput("rstMemWrite", bus.mem_write, 0);
        expQ.delete();
        accepted  = 0;
        popCnt    = 0;
        dropModel = 0;
        @(negedge clk);
        reset   = 1'b0;
        inReset = 1'b0;
    endtask

    task automatic drain(input int maxCycles);
        int n = 0;
        while ((expQ.size() != 0 || bus.out_valid) && n < maxCycles) begin
            applyStimulus(1'b0, '0, 1'b1);
            n++;
        end
        checkOutput("drainTimeout", n >= maxCycles, 0);
    endtask

    // Write-side monitor: RAM write strobe, address and data against the model.
    always @(negedge clk) begin
        #1;
        if (!inReset) begin
            checkOutput("memWrite", bus.mem_write, expWrite);
            if (expWrite) begin
                checkOutput("memAddr", bus.mem_wa, expWa);
                checkOutput("memData", bus.mem_d, expData);
            end
        end
    end

    // Output monitor: pops the scoreboard on each new presentation and checks flags.
    always @(posedge clk) begin
        #1;
        cycle++;
        if (inReset) begin
            prevValid = 1'b0;
            prevData  = '0;
        end else begin
            if (prevValid) begin
                if (bus.out_ack) begin
                    checkOutput("ackClears", bus.out_valid, 0);
                end else begin
                    checkOutput("holdValid", bus.out_valid, 1);
                    checkOutput("holdData", bus.out_data, prevData);
                end
            end
            if (bus.out_valid && !prevValid) begin
                popCnt++;
                riseLog.push_back(cycle);
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedWord", 1, 0);
                end else begin
                    checkOutput("outData", bus.out_data, expQ.pop_front());
                end
            end
            checkOutput("emptyFlag", bus.empty, modelCount() == 0);
            checkOutput("fullFlag", bus.full, modelCount() == DEPTH);
            checkOutput("almostFullFlag", bus.almost_full, modelCount() >= DEPTH - MARGIN);
            checkOutput("dropCnt", bus.drop_cnt, dropModel);
            prevValid = bus.out_valid;
            prevData  = bus.out_data;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        bus.in_en   = 1'b0;
        bus.in_data = '0;
        bus.out_ack = 1'b0;
        resetTask();

        // Single word into an empty queue: valid three cycles after the write.
        applyStimulus(1'b1, 32'hA5, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        #1;
        checkOutput("latencyEarly", bus.out_valid, 0);
        @(posedge clk);
        #2;
        checkOutput("latencyValid", bus.out_valid, 1);
        checkOutput("latencyData", bus.out_data, 32'hA5);
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        #1;
        checkOutput("ackValid", bus.out_valid, 0);
        checkOutput("ackEmpty", bus.empty, 1);

        // Five words held without ack, then drained back-to-back.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h100 + i, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b0);
        #1;
        checkOutput("heldFirst", bus.out_data, 32'h100);
        riseLog.delete();
        for (int i = 0; i < 14; i++) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("burstCount", riseLog.size(), 4);
        for (int i = 1; i < riseLog.size(); i++) begin
            checkOutput("burstGap", riseLog[i] - riseLog[i-1], 2);
        end
        applyStimulus(1'b0, '0, 1'b0);

        // Fill to full without ack, then overflow writes.
        guard = 0;
        while (modelCount() < DEPTH && guard < 1200) begin
            applyStimulus(1'b1, $urandom, 1'b0);
            guard++;
        end
        checkOutput("fillTimeout", guard >= 1200, 0);
        applyStimulus(1'b0, '0, 1'b0);
        #1;
        checkOutput("fullReached", bus.full, 1);
        checkOutput("almostFullAtFull", bus.almost_full, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, $urandom, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        #1;
        checkOutput("dropCount3", bus.drop_cnt, 3);

        // Write while full in the same cycle as an ack: still dropped.
        applyStimulus(1'b1, $urandom, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        #1;
        checkOutput("fullAfterAck", bus.full, 0);
        checkOutput("dropCount4", bus.drop_cnt, 4);
        drain(3000);

        // Reset with a presented word and seven queued entries.
        applyStimulus(1'b1, $urandom, 1'b1);
        applyStimulus(1'b1, $urandom, 1'b1);
        drain(100);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, $urandom, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        #1;
        checkOutput("preResetValid", bus.out_valid, 1);
        checkOutput("preResetDrops", bus.drop_cnt, 4);
        resetTask();

        // Random traffic under continuous ack, long enough to wrap the pointers.
        for (int i = 0; i < 2200; i++) begin
            applyStimulus($urandom_range(0, 99) < 50, $urandom, 1'b1);
        end
        checkOutput("wrapReached", accepted > DEPTH, 1);
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 99) < 50, $urandom, $urandom_range(0, 1) == 1);
        end
        drain(4000);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        #1;
        checkOutput("finalEmpty", bus.empty, 1);
        checkOutput("finalScoreboard", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
